// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core: register-file geometry and small helpers.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
        logic [NUM_REGS-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/inflight_fifo.sv
// Circular queue of in-flight destination registers with push, pop and flush rewind.
module inflight_fifo
    import core_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  reg_addr_t                    push_rd_i,
    input  logic                         pop_i,
    input  logic                         rewind_i,
    input  logic [CNT_W-1:0]             rewind_cnt_i,
    output reg_addr_t                    head_rd_o,
    output logic [CNT_W-1:0]             count_o,
    output logic [MAX_INFLIGHT-1:0]      valid_o,
    output reg_addr_t [MAX_INFLIGHT-1:0] rd_o
);

    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    reg_addr_t [MAX_INFLIGHT-1:0] mem_q;

    // A rewind keeps the oldest entries, so the tail is re-derived from the (post-pop) head.
    always_comb begin
        head_d = head_q + PTR_W'(pop_i);
        if (rewind_i) begin
            count_d = rewind_cnt_i;
            tail_d  = head_d + rewind_cnt_i[PTR_W-1:0];
        end else begin
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
            tail_d  = tail_q + PTR_W'(push_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mem_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i) begin
                mem_q[tail_q] <= push_rd_i;
            end
        end
    end

    // Entry i is live when its distance from head is below the occupancy.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            valid_o[i] = CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q;
        end
    end

    assign head_rd_o = mem_q[head_q];
    assign count_o   = count_q;
    assign rd_o      = mem_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight destinations, stalls on RAW hazards and a full queue.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  uses_rs1_i,
    input  logic                  uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  writes_rd_i,
    output logic                  issue_ready_o,
    output logic                  stall_o,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  flush_i,
    input  logic [CNT_W-1:0]      flush_keep_i,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  error_o
);

    reg_addr_t                    head_rd;
    logic [CNT_W-1:0]             count;
    logic [MAX_INFLIGHT-1:0]      valid;
    reg_addr_t [MAX_INFLIGHT-1:0] rd_q;
    logic [NUM_REGS-1:0]          pending;

    logic hazard, full, empty;
    logic push, wb_eff, pop;
    logic keep_bad, rewind;
    logic [CNT_W-1:0] rewind_cnt;
    logic error_q, error_d;

    inflight_fifo #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_rd_i    (rd_i),
        .pop_i        (pop),
        .rewind_i     (rewind),
        .rewind_cnt_i (rewind_cnt),
        .head_rd_o    (head_rd),
        .count_o      (count),
        .valid_o      (valid),
        .rd_o         (rd_q)
    );

    always_comb begin
        pending = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (valid[i]) begin
                pending = pending | reg_onehot(rd_q[i]);
            end
        end
        pending[ZERO_REG] = 1'b0;
    end

    assign hazard = (uses_rs1_i & pending[rs1_i]) | (uses_rs2_i & pending[rs2_i]);
    assign full   = (count == CNT_W'(MAX_INFLIGHT));
    assign empty  = (count == '0);

    assign issue_ready_o = ~flush_i & ~full & ~hazard;
    assign stall_o       = issue_valid_i & ~issue_ready_o;

    assign push   = issue_valid_i & issue_ready_o & writes_rd_i & (rd_i != ZERO_REG);
    assign wb_eff = wb_valid_i & (wb_rd_i != ZERO_REG);
    assign pop    = wb_eff & ~empty;

    // An over-large keep is rejected outright; the writeback in that cycle still retires normally.
    assign keep_bad   = flush_i & (flush_keep_i > count);
    assign rewind     = flush_i & ~keep_bad;
    assign rewind_cnt = (flush_keep_i == '0) ? '0 : flush_keep_i - CNT_W'(pop);

    assign error_d = error_q
                   | (wb_eff & empty)
                   | (pop & (wb_rd_i != head_rd))
                   | keep_bad
                   | (flush_i & (flush_keep_i == '0) & wb_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign pending_o = pending;
    assign count_o   = count;
    assign error_o   = error_q;

endmodule
